hps_dout_fifo: RTL and testbench

- Avalon-MM slave that returns results from the FPGA fabric to the HPS. It is the read-back counterpart of the HPS write-only data-out PIO.
- Fabric-side producers, such as the MLP output layer, push 32-bit words through a valid/ready handshake into a DEPTH-entry FIFO.
- The HPS drains the FIFO by reading the DATA register and polls STATUS for level and flags.

---
 rtl/hps_dout_pkg.sv | 23 ++
 rtl/hps_dout_fifo_mem.sv | 53 +++++
 rtl/hps_dout_fifo.sv | 138 +++++++++++++
 tb/tb_hps_dout_fifo.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_dout_pkg.sv
// Shared constants for the HPS data-out read-back FIFO: register addresses,
// STATUS/CTRL/CLEAR bit positions and the default data width.
package hps_dout_pkg;

  localparam int DATA_W_DEF = 32;

  // Avalon register addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  // STATUS bit positions; the level field occupies the low bits [PTR_W:0]
  localparam int ST_EMPTY     = 16;
  localparam int ST_FULL      = 17;
  localparam int ST_UNDERFLOW = 18;
  localparam int ST_PWF       = 19;

  // CTRL bit positions
  localparam int CTRL_FLUSH    = 0;
  localparam int CTRL_IRQ_MASK = 1;

endpackage

// File: rtl/hps_dout_fifo_mem.sv
// Storage array, read/write pointers and occupancy counter for the data-out
// FIFO. Callers must only assert push when !full and pop when !empty; flush
// overrides both and returns the FIFO to empty on the next edge.
module hps_dout_fifo_mem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    level,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage write; no reset so the array can map onto RAM/LUT-RAM
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and level bookkeeping; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (level == '0);
  assign full    = (level == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/hps_dout_fifo.sv
// Avalon-MM read-back FIFO from the FPGA fabric to the HPS.
// Fabric producers push words over valid/ready; the HPS pops them by reading
// DATA and polls STATUS for level and sticky error flags.
// Optional feature: define HPS_DOUT_IRQ_EN to implement the CTRL irq_mask bit
// and a registered interrupt; otherwise irq is tied low.
module hps_dout_fifo
  import hps_dout_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              irq
);

  logic              rd_en;
  logic              wr_en;
  logic              pop_req;
  logic              flush;
  logic              push;
  logic              pop;
  logic              underflow_set;
  logic              pwf_set;
  logic              underflow_clr;
  logic              pwf_clr;
  logic              underflow;
  logic              push_while_full;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] rd_next;
  logic [PTR_W:0]    level;
  logic              empty;
  logic              full;

  assign rd_en   = chipselect && !read_n;
  assign wr_en   = chipselect && !write_n;
  assign pop_req = rd_en && (address == ADDR_DATA);
  assign flush   = wr_en && (address == ADDR_CTRL) && writedata[CTRL_FLUSH];

  // Flush takes priority: a concurrent push is dropped and does not count as push-while-full
  assign push          = in_valid && !full && !flush;
  assign pop           = pop_req && !empty && !flush;
  assign underflow_set = pop_req && empty;
  assign pwf_set       = in_valid && full && !flush;
  assign underflow_clr = wr_en && (address == ADDR_CLEAR) && writedata[ST_UNDERFLOW];
  assign pwf_clr       = wr_en && (address == ADDR_CLEAR) && writedata[ST_PWF];

  assign in_ready = !full;

  hps_dout_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (in_data),
    .rd_data (mem_rd_data),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  // Sticky error flags; a set event in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow       <= 1'b0;
      push_while_full <= 1'b0;
    end else begin
      underflow       <= underflow_set || (underflow && !underflow_clr);
      push_while_full <= pwf_set || (push_while_full && !pwf_clr);
    end
  end

`ifdef HPS_DOUT_IRQ_EN
  logic irq_mask;

  // Interrupt mask bit and registered interrupt, recomputed every edge
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (address == ADDR_CTRL)) begin
        irq_mask <= writedata[CTRL_IRQ_MASK];
      end
      irq <= irq_mask && (!empty || underflow || push_while_full);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read data select; DATA returns zero on underflow, CLEAR and unused bits read zero
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: begin
        if (!empty) rd_next = mem_rd_data;
      end
      ADDR_STATUS: begin
        rd_next[PTR_W:0]     = level;
        rd_next[ST_EMPTY]     = empty;
        rd_next[ST_FULL]      = full;
        rd_next[ST_UNDERFLOW] = underflow;
        rd_next[ST_PWF]       = push_while_full;
      end
      ADDR_CTRL: begin
`ifdef HPS_DOUT_IRQ_EN
        rd_next[CTRL_IRQ_MASK] = irq_mask;
`endif
      end
      default: rd_next = '0;
    endcase
  end

  // Registered read data; holds its value between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_en) begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_hps_dout_fifo.sv
// Self-checking bench for hps_dout_fifo. A queue-based reference model tracks
// FIFO contents and flags at every rising edge and queues the expected
// readdata for each bus read; reads pop and compare one cycle later.
module tb_hps_dout_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        address;
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [31:0]       writedata;
  logic [DATA_W-1:0] readdata;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              irq;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // reference model state
  logic [31:0] sb[$];
  logic [31:0] exp_q[$];
  logic        m_und, m_pwf, m_mask, m_irq;

  hps_dout_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    n = sb.size();
    s = '0;
    s[4:0] = n[4:0];
    s[16]  = (n == 0);
    s[17]  = (n == DEPTH);
    s[18]  = m_und;
    s[19]  = m_pwf;
    return s;
  endfunction

  // Reference model: evaluated on each rising edge from the inputs driven at the previous falling edge
  always @(posedge clk) begin
    logic rd, wr, fl, emp, ful, und_set, pwf_set, irq_n;
    if (reset) begin
      sb.delete();
      exp_q.delete();
      m_und = 0; m_pwf = 0; m_mask = 0; m_irq = 0;
    end else begin
      rd  = chipselect && !read_n;
      wr  = chipselect && !write_n;
      fl  = wr && address == 2'd2 && writedata[0];
      emp = (sb.size() == 0);
      ful = (sb.size() == DEPTH);
      if (rd) begin
        case (address)
          2'd0: exp_q.push_back(emp ? 32'h0 : sb[0]);
          2'd1: exp_q.push_back(m_status());
`ifdef HPS_DOUT_IRQ_EN
          2'd2: exp_q.push_back({30'h0, m_mask, 1'b0});
`else
          2'd2: exp_q.push_back(32'h0);
`endif
          default: exp_q.push_back(32'h0);
        endcase
      end
`ifdef HPS_DOUT_IRQ_EN
      irq_n = m_mask && (!emp || m_und || m_pwf);
      if (wr && address == 2'd2) m_mask = writedata[1];
`else
      irq_n = 1'b0;
`endif
      und_set = rd && address == 2'd0 && emp;
      pwf_set = in_valid && ful && !fl;
      m_und = und_set || (m_und && !(wr && address == 2'd3 && writedata[18]));
      m_pwf = pwf_set || (m_pwf && !(wr && address == 2'd3 && writedata[19]));
      m_irq = irq_n;
      if (fl) begin
        sb.delete();
      end else begin
        if (rd && address == 2'd0 && !emp) void'(sb.pop_front());
        if (in_valid && !ful) sb.push_back(in_data);
      end
    end
  end

  // Handshake and interrupt are checked every cycle against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'h0, in_ready}, {31'h0, sb.size() != DEPTH});
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
    end
  end

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    chipselect = 1; read_n = 0; address = a;
    @(negedge clk);
    chipselect = 0; read_n = 1;
    v = readdata;
    chk("exp_q_size", exp_q.size(), 1);
    if (exp_q.size() > 0) chk($sformatf("rd_a%0d", a), readdata, exp_q.pop_front());
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write_n = 1; writedata = 0;
  endtask

  task automatic push_word(input logic [31:0] d);
    in_valid = 1; in_data = d;
    @(negedge clk);
    in_valid = 0;
  endtask

  initial begin
    logic [31:0] v;
    reset = 1; chipselect = 0; read_n = 1; write_n = 1; address = 0;
    writedata = 0; in_data = 0; in_valid = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    chk_en = 1;

    // reset state
    chk("rdata_reset", readdata, 32'h0);
    rd_reg(2'd1, v);
    chk("st_reset", v, 32'h0001_0000);

    // simple in-order transfer
    for (int i = 1; i <= 3; i++) push_word(32'hDEAD_0000 + i);
    for (int i = 1; i <= 3; i++) begin
      rd_reg(2'd0, v);
      chk("data_order", v, 32'hDEAD_0000 + i);
    end
    rd_reg(2'd1, v);
    chk("st_drained", v, 32'h0001_0000);

    // fill to full with a 17th word held valid
    in_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 32'h100 + i;
      @(negedge clk);
    end
    in_data = 32'h1FF;
    @(negedge clk);
    chk("rdy_full", {31'h0, in_ready}, 32'h0);
    rd_reg(2'd1, v);
    chk("st_full", v, 32'h000A_0010);
    rd_reg(2'd0, v);
    chk("pop_full", v, 32'h100);
    @(negedge clk);
    in_valid = 0;
    rd_reg(2'd1, v);
    chk("st_refill", v, 32'h000A_0010);
    for (int i = 0; i < DEPTH; i++) rd_reg(2'd0, v);
    chk("last_word", v, 32'h1FF);
    rd_reg(2'd1, v);
    chk("st_pwf_empty", v, 32'h0009_0000);
    wr_reg(2'd3, 32'h0008_0000);
    rd_reg(2'd1, v);
    chk("st_pwf_clr", v, 32'h0001_0000);

    // underflow, clear, and underflow coinciding with a push
    rd_reg(2'd0, v);
    chk("under_data", v, 32'h0);
    rd_reg(2'd1, v);
    chk("st_under", v, 32'h0005_0000);
    wr_reg(2'd3, 32'h0004_0000);
    rd_reg(2'd1, v);
    chk("st_under_clr", v, 32'h0001_0000);
    in_valid = 1; in_data = 32'hCAFE;
    rd_reg(2'd0, v);
    in_valid = 0;
    chk("under_push_data", v, 32'h0);
    rd_reg(2'd1, v);
    chk("st_under_push", v, 32'h0004_0001);
    rd_reg(2'd0, v);
    chk("no_bypass", v, 32'hCAFE);
    wr_reg(2'd3, 32'h0004_0000);

    // flush with a concurrent push
    for (int i = 0; i < 5; i++) push_word(32'h500 + i);
    in_valid = 1; in_data = 32'h5FF;
    wr_reg(2'd2, 32'h1);
    in_valid = 0;
    rd_reg(2'd1, v);
    chk("st_flush", v, 32'h0001_0000);
    rd_reg(2'd2, v);

    // interrupt behaviour
    wr_reg(2'd2, 32'h2);
    push_word(32'h77);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clk);
`ifdef HPS_DOUT_IRQ_EN
    chk("irq_on", {31'h0, irq}, 32'h1);
`else
    chk("irq_off", {31'h0, irq}, 32'h0);
`endif
    rd_reg(2'd0, v);
    chk("irq_word", v, 32'h77);
    @(negedge clk);
    chk("irq_clear", {31'h0, irq}, 32'h0);
    rd_reg(2'd2, v);
    wr_reg(2'd2, 32'h0);

    // reset mid-transfer discards contents
    for (int i = 0; i < 3; i++) push_word(32'h900 + i);
    reset = 1;
    @(negedge clk);
    reset = 0;
    rd_reg(2'd1, v);
    chk("st_midreset", v, 32'h0001_0000);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
